// File: rtl/xorshift_pkg.sv
// Shared constants and state type for the xorshift stream generator.
// Defaults here are the classic 32-bit xorshift triple and fallback seed.
package xorshift_pkg;

  localparam int SH_A_DEF = 13;
  localparam int SH_B_DEF = 17;
  localparam int SH_C_DEF = 5;

  localparam logic [63:0] SEED_DEF = 64'h2545_F491;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/xorshift_step.sv
// One combinational xorshift round: left, right, left shift-xor.
// Shifts are logical and truncate to WIDTH.
module xorshift_step #(
  parameter int WIDTH = 32,
  parameter int SH_A  = 13,
  parameter int SH_B  = 17,
  parameter int SH_C  = 5
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] t1;
  logic [WIDTH-1:0] t2;

  always_comb begin
    t1 = x ^ (x << SH_A);
    t2 = t1 ^ (t1 >> SH_B);
    y  = t2 ^ (t2 << SH_C);
  end

endmodule

// File: rtl/xorshift_stream_gen.sv
// Burst generator: accepts seed/count, streams count xorshift words
// over a valid/ready port, then pulses done.
module xorshift_stream_gen
  import xorshift_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               SH_A         = SH_A_DEF,
  parameter int               SH_B         = SH_B_DEF,
  parameter int               SH_C         = SH_C_DEF,
  parameter int               CNT_W        = 8,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(SEED_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rand_num,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W:0] ONE  = (CNT_W+1)'(1);
  localparam logic [CNT_W:0] FULL = {1'b1, {CNT_W{1'b0}}};

  state_e           state;
  logic [CNT_W:0]   remaining;
  logic [WIDTH-1:0] seed_eff;
  logic [WIDTH-1:0] seed_next;
  logic [WIDTH-1:0] rand_next;
  logic [CNT_W:0]   cnt_load;
  logic             xfer;
  logic             fin;
  logic             stop;

  // A zero state would lock xorshift at zero forever.
  assign seed_eff = (seed == '0) ? SEED_DEFAULT : seed;
  assign cnt_load = (count == '0) ? FULL : {1'b0, count};

  assign xfer = (state == RUN) & out_ready;
  assign fin  = xfer & (remaining == ONE);
  assign stop = abort & ~fin;

  xorshift_step #(
    .WIDTH (WIDTH),
    .SH_A  (SH_A),
    .SH_B  (SH_B),
    .SH_C  (SH_C)
  ) u_seed_step (
    .x (seed_eff),
    .y (seed_next)
  );

  xorshift_step #(
    .WIDTH (WIDTH),
    .SH_A  (SH_A),
    .SH_B  (SH_B),
    .SH_C  (SH_C)
  ) u_run_step (
    .x (rand_num),
    .y (rand_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rand_num  <= '0;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            state     <= RUN;
            rand_num  <= seed_next;
            remaining <= cnt_load;
          end
        end
        RUN: begin
          if (xfer) begin
            rand_num  <= rand_next;
            remaining <= remaining - ONE;
          end
          // Final transfer wins over a coincident abort.
          unique case (1'b1)
            fin: begin
              state <= IDLE;
              done  <= 1'b1;
            end
            stop: begin
              state <= IDLE;
            end
            default: begin
            end
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == RUN);

endmodule

// File: tb/tb_xorshift_stream_gen.sv
// Scoreboard bench for xorshift_stream_gen: 32-bit and 64-bit instances,
// directed bursts with hand-derived words and a reference step model.
module tb_xorshift_stream_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv32, ir32, ab32, ov32, or32, busy32, done32;
  logic [31:0] seed32, rn32;
  logic [7:0]  cnt32;

  logic        iv64, ir64, ab64, ov64, or64, busy64, done64;
  logic [63:0] seed64, rn64;
  logic [7:0]  cnt64;

  xorshift_stream_gen u_d32 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv32),
    .in_ready  (ir32),
    .seed      (seed32),
    .count     (cnt32),
    .abort     (ab32),
    .out_valid (ov32),
    .out_ready (or32),
    .rand_num  (rn32),
    .busy      (busy32),
    .done      (done32)
  );

  xorshift_stream_gen #(.WIDTH(64)) u_d64 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv64),
    .in_ready  (ir64),
    .seed      (seed64),
    .count     (cnt64),
    .abort     (ab64),
    .out_valid (ov64),
    .out_ready (or64),
    .rand_num  (rn64),
    .busy      (busy64),
    .done      (done64)
  );

  int tests = 0;
  int fails = 0;
  int x32 = 0;
  int x64 = 0;

  logic [63:0] q32[$];
  logic [63:0] q64[$];
  bit          l32[$];
  bit          l64[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(logic [63:0] x, bit w64);
    logic [63:0] m;
    logic [63:0] t1;
    logic [63:0] t2;
    m  = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    t1 = (x ^ (x << 13)) & m;
    t2 = t1 ^ (t1 >> 17);
    return (t2 ^ (t2 << 5)) & m;
  endfunction

  task automatic push(bit w64, logic [63:0] v, bit last);
    if (w64) begin
      q64.push_back(v);
      l64.push_back(last);
    end else begin
      q32.push_back(v);
      l32.push_back(last);
    end
  endtask

  task automatic push_model(bit w64, logic [63:0] s, int n);
    logic [63:0] v;
    v = s;
    for (int i = 0; i < n; i++) begin
      v = model(v, w64);
      push(w64, v, i == n - 1);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic req(bit w64, logic [63:0] s, logic [7:0] c);
    if (w64) begin
      seed64 = s;
      cnt64  = c;
      iv64   = 1'b1;
    end else begin
      seed32 = s[31:0];
      cnt32  = c;
      iv32   = 1'b1;
    end
    cyc(1);
    iv32 = 1'b0;
    iv64 = 1'b0;
  endtask

  task automatic wait_done(bit w64, int budget, string name);
    int k;
    int qs;
    for (k = 0; k < budget; k++) begin
      cyc(1);
      qs = w64 ? q64.size() : q32.size();
      if ((w64 ? ir64 : ir32) && qs == 0) break;
    end
    if (k == budget) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got busy after %0d cycles required done", name, budget);
    end else begin
      chk(name, {63'h0, w64 ? done64 : done32}, 64'h1);
    end
  endtask

  task automatic mon(bit w64);
    bit          expd;
    bit          l;
    logic [63:0] e;
    logic [63:0] act;
    logic        d;
    expd = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        expd = 1'b0;
      end else begin
        d = w64 ? done64 : done32;
        if (d !== expd || expd)
          chk(w64 ? "mon_done64" : "mon_done32", {63'h0, d}, {63'h0, expd});
        expd = 1'b0;
        act  = w64 ? rn64 : {32'h0, rn32};
        if (w64 ? (ov64 && or64) : (ov32 && or32)) begin
          if ((w64 ? q64.size() : q32.size()) == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out: got %h required no transfer", act);
          end else begin
            if (w64) begin
              e = q64.pop_front();
              l = l64.pop_front();
              x64++;
            end else begin
              e = q32.pop_front();
              l = l32.pop_front();
              x32++;
            end
            chk(w64 ? "rand64" : "rand32", act, e);
            expd = l;
          end
        end
      end
    end
  endtask

  int base;

  initial begin
    rst = 1'b1;
    iv32 = 1'b0; or32 = 1'b0; ab32 = 1'b0; seed32 = '0; cnt32 = '0;
    iv64 = 1'b0; or64 = 1'b0; ab64 = 1'b0; seed64 = '0; cnt64 = '0;
    fork
      mon(1'b0);
      mon(1'b1);
    join_none

    cyc(3);
    chk("rst_out_valid", {63'h0, ov32}, 64'h0);
    chk("rst_busy", {63'h0, busy32}, 64'h0);
    chk("rst_in_ready", {63'h0, ir32}, 64'h1);
    chk("rst_rand", {32'h0, rn32}, 64'h0);
    chk("rst_done", {63'h0, done32}, 64'h0);
    chk("rst_rand64", rn64, 64'h0);
    rst = 1'b0;

    // seed=1, count=3, hand-derived sequence
    or32 = 1'b1;
    push(1'b0, 64'h0004_2021, 1'b0);
    push(1'b0, 64'h0408_0601, 1'b0);
    push(1'b0, 64'h9DCC_A8C5, 1'b1);
    req(1'b0, 64'h1, 8'd3);
    wait_done(1'b0, 20, "done_seq3");
    chk("seq3_ov_after", {63'h0, ov32}, 64'h0);

    ab32 = 1'b1;
    cyc(2);
    chk("abort_idle_ready", {63'h0, ir32}, 64'h1);
    chk("abort_idle_busy", {63'h0, busy32}, 64'h0);
    ab32 = 1'b0;

    // zero seed takes the default
    or32 = 1'b0;
    push_model(1'b0, 64'h2545_F491, 1);
    req(1'b0, 64'h0, 8'd1);
    chk("seed0_valid", {63'h0, ov32}, 64'h1);
    chk("seed0_nonzero", {63'h0, rn32 != 32'h0}, 64'h1);
    or32 = 1'b1;
    wait_done(1'b0, 20, "done_seed0");

    // backpressure hold, with an ignored request in RUN
    or32 = 1'b0;
    push(1'b0, 64'h0004_2021, 1'b0);
    push(1'b0, 64'h0408_0601, 1'b1);
    req(1'b0, 64'h1, 8'd2);
    iv32 = 1'b1; seed32 = 32'h7; cnt32 = 8'd5;
    for (int i = 0; i < 5; i++) begin
      chk("hold_rand", {32'h0, rn32}, 64'h0004_2021);
      cyc(1);
      iv32 = 1'b0;
    end
    or32 = 1'b1;
    wait_done(1'b0, 20, "done_hold");
    cyc(3);
    chk("hold_no_extra", {63'h0, ov32}, 64'h0);

    // count=0 means 256
    base = x32;
    push_model(1'b0, 64'h1, 256);
    req(1'b0, 64'h1, 8'd0);
    wait_done(1'b0, 400, "done_256");
    chk("c256_ov_257", {63'h0, ov32}, 64'h0);
    chk("c256_xfers", 64'(x32 - base), 64'd256);

    // abort after 2 of 10
    or32 = 1'b0;
    base = x32;
    push_model(1'b0, 64'h1, 10);
    req(1'b0, 64'h1, 8'd10);
    or32 = 1'b1;
    cyc(2);
    or32 = 1'b0;
    ab32 = 1'b1;
    cyc(1);
    ab32 = 1'b0;
    q32.delete();
    l32.delete();
    chk("abort_ov", {63'h0, ov32}, 64'h0);
    chk("abort_ready", {63'h0, ir32}, 64'h1);
    chk("abort_done", {63'h0, done32}, 64'h0);
    chk("abort_xfers", 64'(x32 - base), 64'd2);
    cyc(1);
    chk("abort_done_late", {63'h0, done32}, 64'h0);

    // abort coincident with the final transfer
    or32 = 1'b1;
    push(1'b0, 64'h0004_2021, 1'b0);
    push(1'b0, 64'h0408_0601, 1'b1);
    req(1'b0, 64'h1, 8'd2);
    cyc(1);
    ab32 = 1'b1;
    cyc(1);
    ab32 = 1'b0;
    chk("abort_fin_done", {63'h0, done32}, 64'h1);
    chk("abort_fin_ov", {63'h0, ov32}, 64'h0);

    // new request accepted during the done cycle
    push(1'b0, 64'h0004_2021, 1'b1);
    req(1'b0, 64'h1, 8'd1);
    chk("b2b_valid", {63'h0, ov32}, 64'h1);
    wait_done(1'b0, 20, "done_b2b");

    // reset mid-burst
    push_model(1'b0, 64'h1, 10);
    req(1'b0, 64'h1, 8'd10);
    cyc(3);
    rst = 1'b1;
    cyc(1);
    q32.delete();
    l32.delete();
    chk("mid_rst_ov", {63'h0, ov32}, 64'h0);
    chk("mid_rst_busy", {63'h0, busy32}, 64'h0);
    chk("mid_rst_ready", {63'h0, ir32}, 64'h1);
    chk("mid_rst_rand", {32'h0, rn32}, 64'h0);
    chk("mid_rst_done", {63'h0, done32}, 64'h0);
    rst = 1'b0;
    cyc(1);
    chk("mid_rst_done_late", {63'h0, done32}, 64'h0);
    chk("rst_ov64", {63'h0, ov64}, 64'h0);

    // 64-bit instance
    or64 = 1'b1;
    push(1'b1, 64'h0000_0000_0004_2021, 1'b0);
    push(1'b1, 64'h0000_0010_0408_0601, 1'b0);
    push_model(1'b1, 64'h0000_0010_0408_0601, 18);
    req(1'b1, 64'h1, 8'd20);
    wait_done(1'b1, 60, "done_w64");
    chk("w64_xfers", 64'(x64), 64'd20);

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/xorshift_stream_gen.md
XORSHIFT_STREAM_GEN -- requirements
Module: xorshift_stream_gen

Interface
REQ-001 Parameter WIDTH, default 32: generator word width; legal values 32 or 64.
REQ-002 Parameter SH_A / SH_B / SH_C, defaults 13 / 17 / 5: left, right, left shift amounts; each SHALL be in 1..WIDTH-1.
REQ-003 Parameter CNT_W, default 8: width of the burst-length field.
REQ-004 Parameter SEED_DEFAULT, default 32'h2545F491 zero-extended to WIDTH: substitute for a zero seed; SHALL be nonzero.
REQ-005 The block SHALL use one clock, clk; reset is rst, synchronous and active-high.
REQ-006 clk  in  1  sole clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 in_valid  in  1  seed/count request valid.
REQ-009 in_ready  out  1  request accepted when in_valid and in_ready are both high.
REQ-010 seed  in  WIDTH  initial generator state.
REQ-011 count  in  CNT_W  numbers to emit; 0 means 2^CNT_W.
REQ-012 abort  in  1  terminate the current burst.
REQ-013 out_valid  out  1  rand_num valid.
REQ-014 out_ready  in  1  downstream accepts rand_num.
REQ-015 rand_num  out  WIDTH  generated number.
REQ-016 busy  out  1  burst in progress.
REQ-017 done  out  1  one-cycle pulse after the final number transfers.

Function
REQ-018 step(x): t1 = x ^ (x << SH_A); t2 = t1 ^ (t1 >> SH_B); step = t2 ^ (t2 << SH_C); all logical shifts, truncated to WIDTH.
REQ-019 FSM states: IDLE and RUN; in_ready = (state == IDLE); busy = (state == RUN); out_valid = (state == RUN).
REQ-020 IDLE -> RUN on accept at edge T: rand_num <= step(s), where s = seed, or SEED_DEFAULT if seed == 0; remaining <= count (0 loads 2^CNT_W); out_valid goes high in cycle T+1.
REQ-021 A transfer (out_valid & out_ready) SHALL load rand_num <= step(rand_num) and decrement remaining.
REQ-022 A transfer with remaining == 1 SHALL return the FSM to IDLE, pulse done for exactly the next cycle, and drop out_valid.
REQ-023 While out_valid is high and out_ready is low, rand_num and remaining SHALL hold stable.
REQ-024 abort in RUN without a final transfer SHALL return the FSM to IDLE next cycle; out_valid drops and done stays low.
REQ-025 abort coincident with the final transfer SHALL complete normally, with done pulsed.
REQ-026 abort in IDLE SHALL be ignored; in_valid in RUN SHALL be ignored and not queued.
REQ-027 A new request MAY be accepted in the cycle done is high; its first output follows one cycle later.
REQ-028 rand_num SHALL be driven from a register, with no combinational path from out_ready to rand_num or out_valid.
REQ-029 Throughput SHALL be one number per cycle while out_ready is held high.

Reset
REQ-030 While rst is high at a clk edge: state <= IDLE, rand_num <= 0, remaining <= 0, done <= 0; out_valid, busy are 0 and in_ready is 1 in the following cycle.
REQ-031 Reset asserted during RUN SHALL abandon the burst without a done pulse.

Structure
REQ-032 Package xorshift_pkg SHALL hold the default shift constants, the default SEED_DEFAULT, and the state enum {IDLE, RUN}.
REQ-033 The step function SHALL be a combinational sub-module xorshift_step, parametrised by WIDTH, SH_A, SH_B and SH_C.

Verification
REQ-034 WIDTH=32 defaults, seed=1, count=3, out_ready=1 -> rand_num 0x00042021, 0x04080601, then the third value; done is high the cycle after the third transfer.
REQ-035 seed=0, count=1 -> rand_num = step(0x2545F491); no all-zero output.
REQ-036 seed=1, count=2, out_ready low for 5 cycles after out_valid -> 0x00042021 held for 5 cycles; sequence unchanged afterwards.
REQ-037 count=0, CNT_W=8 -> exactly 256 transfers, then one done pulse; the 257th cycle has out_valid=0.
REQ-038 abort after 2 of 10 transfers -> out_valid=0 next cycle, no done pulse, in_ready=1; abort with the final transfer -> done pulses.
REQ-039 rst mid-burst, then WIDTH=64 instance with seed=1 -> outputs are 0 immediately after reset, and the 64-bit run matches a software model of the step function.
